gfx_bus_arbiter: RTL and testbench

- Shares the graphics register bus (chipselect/read/4-bit register address/16-bit data) between two masters: req0 (CPU bus bridge) and req1 (game physics engine).
- Round-robin arbitration, one beat per cycle.
- Locked bursts keep multi-register updates atomic, e.g. the paddle x/y pair.
- Flags bursts torn by the frame-latch boundary; sits directly in front of the graphics ASIC register file.

---
 rtl/gfx_bus_arbiter_pkg.sv | 19 +
 rtl/gfx_bus_arbiter_pick.sv | 12 +
 rtl/gfx_bus_arbiter.sv | 147 ++++++++++++++
 tb/tb_gfx_bus_arbiter.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/gfx_bus_arbiter_pkg.sv
// rtl/gfx_bus_arbiter_pkg.sv - shared register map and arbiter state type
package gfx_bus_arbiter_pkg;

    localparam logic [3:0] PADDLE1_X   = 4'd0;
    localparam logic [3:0] PADDLE1_Y   = 4'd1;
    localparam logic [3:0] PADDLE2_X   = 4'd2;
    localparam logic [3:0] PADDLE2_Y   = 4'd3;
    localparam logic [3:0] BALL_X      = 4'd4;
    localparam logic [3:0] BALL_Y      = 4'd5;
    localparam logic [3:0] SCORE_P1    = 4'd6;
    localparam logic [3:0] SCORE_P2    = 4'd7;
    localparam logic [3:0] FRAME_COUNT = 4'd8;
    localparam logic [3:0] GAME_STATE  = 4'd9;

    localparam int GFX_NUM_REGS = 10;

    typedef enum logic {IDLE, BURST} arb_state_t;

endpackage

// File: rtl/gfx_bus_arbiter_pick.sv
// rtl/gfx_bus_arbiter_pick.sv - 2-way round-robin grant selector
module gfx_rr_pick (
    input  logic valid0,
    input  logic valid1,
    input  logic last_grant,
    output logic grant,
    output logic any
);
    // On a tie the master that did not win last time goes first.
    assign grant = (valid0 && valid1) ? ~last_grant : valid1;
    assign any   = valid0 | valid1;
endmodule

// File: rtl/gfx_bus_arbiter.sv
// rtl/gfx_bus_arbiter.sv - two-master arbiter for the graphics register bus
module gfx_bus_arbiter
    import gfx_bus_arbiter_pkg::*;
#(
    parameter int NUM_REGS     = GFX_NUM_REGS,
    parameter int MAX_LOCK     = 4,
    parameter int LOCK_TIMEOUT = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_end,
    input  logic        req0_valid,
    input  logic        req0_write,
    input  logic        req0_lock,
    input  logic [3:0]  req0_addr,
    input  logic [15:0] req0_wdata,
    output logic        req0_ready,
    output logic        req0_rvalid,
    output logic [15:0] req0_rdata,
    output logic        req0_err,
    input  logic        req1_valid,
    input  logic        req1_write,
    input  logic        req1_lock,
    input  logic [3:0]  req1_addr,
    input  logic [15:0] req1_wdata,
    output logic        req1_ready,
    output logic        req1_rvalid,
    output logic [15:0] req1_rdata,
    output logic        req1_err,
    output logic        gfx_chipselect,
    output logic        gfx_read,
    output logic [3:0]  gfx_addr,
    output logic [15:0] gfx_wdata,
    input  logic [15:0] gfx_rdata,
    output logic        torn
);
    localparam int BW = $clog2(MAX_LOCK + 1);
    localparam int IW = $clog2(LOCK_TIMEOUT + 1);

    arb_state_t    state;
    logic          last_grant;
    logic          owner;
    logic [BW-1:0] beats;
    logic [IW-1:0] idle_cnt;
    logic          gfx_id;

    logic          pick_grant, pick_any;
    logic          xfer, xfer_id, x_write, x_lock, addr_ok, last_beat;
    logic [3:0]    x_addr;
    logic [15:0]   x_wdata;

    gfx_rr_pick u_pick (
        .valid0     (req0_valid),
        .valid1     (req1_valid),
        .last_grant (last_grant),
        .grant      (pick_grant),
        .any        (pick_any)
    );

    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        if (state == IDLE) begin
            req0_ready = pick_any && !pick_grant;
            req1_ready = pick_any && pick_grant;
        end else begin
            req0_ready = !owner && req0_valid;
            req1_ready = owner && req1_valid;
        end
    end

    // Ready is only ever raised alongside valid, so ready alone marks a transfer.
    assign xfer      = req0_ready | req1_ready;
    assign xfer_id   = req1_ready;
    assign x_write   = xfer_id ? req1_write : req0_write;
    assign x_lock    = xfer_id ? req1_lock  : req0_lock;
    assign x_addr    = xfer_id ? req1_addr  : req0_addr;
    assign x_wdata   = xfer_id ? req1_wdata : req0_wdata;
    assign addr_ok   = int'(x_addr) < NUM_REGS;
    assign last_beat = (state == BURST) && xfer &&
                       (!x_lock || beats == BW'(MAX_LOCK - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            last_grant     <= 1'b1;
            owner          <= 1'b0;
            beats          <= '0;
            idle_cnt       <= '0;
            gfx_id         <= 1'b0;
            gfx_chipselect <= 1'b0;
            gfx_read       <= 1'b0;
            gfx_addr       <= '0;
            gfx_wdata      <= '0;
            req0_rvalid    <= 1'b0;
            req1_rvalid    <= 1'b0;
            req0_rdata     <= '0;
            req1_rdata     <= '0;
            req0_err       <= 1'b0;
            req1_err       <= 1'b0;
            torn           <= 1'b0;
        end else begin
            gfx_chipselect <= xfer && addr_ok;
            gfx_read       <= xfer && addr_ok && !x_write;
            gfx_addr       <= (xfer && addr_ok) ? x_addr : 4'd0;
            gfx_wdata      <= (xfer && addr_ok && x_write) ? x_wdata : 16'd0;
            gfx_id         <= xfer_id;
            req0_err       <= xfer && !addr_ok && !xfer_id;
            req1_err       <= xfer && !addr_ok && xfer_id;

            req0_rvalid <= gfx_chipselect && gfx_read && !gfx_id;
            req1_rvalid <= gfx_chipselect && gfx_read && gfx_id;
            if (gfx_chipselect && gfx_read && !gfx_id) req0_rdata <= gfx_rdata;
            if (gfx_chipselect && gfx_read && gfx_id)  req1_rdata <= gfx_rdata;

            // A burst closing on its own final beat is not torn by the frame latch.
            torn <= frame_end && (state == BURST) && !last_beat;

            case (state)
                IDLE: begin
                    if (xfer) begin
                        last_grant <= xfer_id;
                        if (x_lock && MAX_LOCK > 1) begin
                            state    <= BURST;
                            owner    <= xfer_id;
                            beats    <= BW'(1);
                            idle_cnt <= '0;
                        end
                    end
                end
                BURST: begin
                    if (xfer) begin
                        beats    <= beats + BW'(1);
                        idle_cnt <= '0;
                        if (last_beat) state <= IDLE;
                    end else if (idle_cnt == IW'(LOCK_TIMEOUT - 1)) begin
                        state    <= IDLE;
                        idle_cnt <= '0;
                    end else begin
                        idle_cnt <= idle_cnt + IW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_gfx_bus_arbiter.sv
// tb/tb_gfx_bus_arbiter.sv - self-checking bench for gfx_bus_arbiter
module tb_gfx_bus_arbiter;
    localparam int M_NUM_REGS = 10;
    localparam int M_MAX_LOCK = 4;
    localparam int M_TIMEOUT  = 8;

    logic        clk = 1'b0;
    logic        rst, frame_end;
    logic        req0_valid, req0_write, req0_lock, req0_ready, req0_rvalid, req0_err;
    logic [3:0]  req0_addr;
    logic [15:0] req0_wdata, req0_rdata;
    logic        req1_valid, req1_write, req1_lock, req1_ready, req1_rvalid, req1_err;
    logic [3:0]  req1_addr;
    logic [15:0] req1_wdata, req1_rdata;
    logic        gfx_chipselect, gfx_read, torn;
    logic [3:0]  gfx_addr;
    logic [15:0] gfx_wdata, gfx_rdata;

    always #5 clk = ~clk;

    gfx_bus_arbiter dut (
        .clk(clk), .rst(rst), .frame_end(frame_end),
        .req0_valid(req0_valid), .req0_write(req0_write), .req0_lock(req0_lock),
        .req0_addr(req0_addr), .req0_wdata(req0_wdata), .req0_ready(req0_ready),
        .req0_rvalid(req0_rvalid), .req0_rdata(req0_rdata), .req0_err(req0_err),
        .req1_valid(req1_valid), .req1_write(req1_write), .req1_lock(req1_lock),
        .req1_addr(req1_addr), .req1_wdata(req1_wdata), .req1_ready(req1_ready),
        .req1_rvalid(req1_rvalid), .req1_rdata(req1_rdata), .req1_err(req1_err),
        .gfx_chipselect(gfx_chipselect), .gfx_read(gfx_read), .gfx_addr(gfx_addr),
        .gfx_wdata(gfx_wdata), .gfx_rdata(gfx_rdata), .torn(torn)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(string name, logic [15:0] act, logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: who owns the bus, how many beats used, and what the bus shows next.
    int          m_owner, m_last, m_beats, m_quiet, m_gid;
    logic        m_cs, m_rd, m_torn;
    logic [3:0]  m_addr;
    logic [15:0] m_wd;
    logic [1:0]  m_err, m_rv;
    logic [15:0] m_rdat [2];

    function automatic int winner();
        if (m_owner >= 0) return ((m_owner == 0) ? req0_valid : req1_valid) ? m_owner : -1;
        if (req0_valid && req1_valid) return 1 - m_last;
        if (req0_valid) return 0;
        if (req1_valid) return 1;
        return -1;
    endfunction

    task automatic model_compare(string tag);
        int w;
        w = winner();
        chk({tag, " ready0"},  16'(req0_ready), 16'(w == 0));
        chk({tag, " ready1"},  16'(req1_ready), 16'(w == 1));
        chk({tag, " cs"},      16'(gfx_chipselect), 16'(m_cs));
        chk({tag, " read"},    16'(gfx_read), 16'(m_rd));
        chk({tag, " addr"},    16'(gfx_addr), 16'(m_addr));
        chk({tag, " wdata"},   gfx_wdata, m_wd);
        chk({tag, " err0"},    16'(req0_err), 16'(m_err[0]));
        chk({tag, " err1"},    16'(req1_err), 16'(m_err[1]));
        chk({tag, " rvalid0"}, 16'(req0_rvalid), 16'(m_rv[0]));
        chk({tag, " rvalid1"}, 16'(req1_rvalid), 16'(m_rv[1]));
        chk({tag, " rdata0"},  req0_rdata, m_rdat[0]);
        chk({tag, " rdata1"},  req1_rdata, m_rdat[1]);
        chk({tag, " torn"},    16'(torn), 16'(m_torn));
    endtask

    task automatic model_step();
        int w;
        logic wr, lk, fin, ok;
        logic [3:0] a;
        logic [15:0] d;
        if (rst) begin
            m_owner = -1; m_last = 1; m_beats = 0; m_quiet = 0; m_gid = 0;
            m_cs = 0; m_rd = 0; m_addr = 0; m_wd = 0; m_err = 0; m_rv = 0;
            m_rdat[0] = 0; m_rdat[1] = 0; m_torn = 0;
            return;
        end
        w  = winner();
        wr = (w == 1) ? req1_write : req0_write;
        lk = (w == 1) ? req1_lock  : req0_lock;
        a  = (w == 1) ? req1_addr  : req0_addr;
        d  = (w == 1) ? req1_wdata : req0_wdata;
        ok = (w >= 0) && (int'(a) < M_NUM_REGS);
        for (int k = 0; k < 2; k++) begin
            m_rv[k] = m_cs && m_rd && (m_gid == k);
            if (m_rv[k]) m_rdat[k] = gfx_rdata;
        end
        fin    = (w >= 0) && (m_owner >= 0) && (!lk || m_beats + 1 == M_MAX_LOCK);
        m_torn = frame_end && (m_owner >= 0) && !fin;
        m_err[0] = (w == 0) && !ok;
        m_err[1] = (w == 1) && !ok;
        m_cs   = ok;
        m_rd   = ok && !wr;
        m_addr = ok ? a : 4'd0;
        m_wd   = (ok && wr) ? d : 16'd0;
        if (w >= 0) m_gid = w;
        if (m_owner < 0) begin
            if (w >= 0) begin
                m_last = w;
                if (lk) begin m_owner = w; m_beats = 1; m_quiet = 0; end
            end
        end else if (w >= 0) begin
            m_beats++; m_quiet = 0;
            if (fin) m_owner = -1;
        end else begin
            m_quiet++;
            if (m_quiet == M_TIMEOUT) begin m_owner = -1; m_quiet = 0; end
        end
    endtask

    typedef struct {
        logic rst, fe;
        logic v0, w0, l0; logic [3:0] a0; logic [15:0] d0;
        logic v1, w1, l1; logic [3:0] a1; logic [15:0] d1;
        logic r0, r1, cs; logic [3:0] addr; logic [15:0] wd;
        logic rv1, err0, torn;
    } vec_t;

    function automatic vec_t mk(logic rs, logic fe,
                                logic v0, logic w0, logic l0, logic [3:0] a0, logic [15:0] d0,
                                logic v1, logic w1, logic l1, logic [3:0] a1, logic [15:0] d1,
                                logic r0, logic r1, logic cs, logic [3:0] ad, logic [15:0] wd,
                                logic rv1, logic er0, logic tn);
        vec_t v;
        v.rst = rs; v.fe = fe;
        v.v0 = v0; v.w0 = w0; v.l0 = l0; v.a0 = a0; v.d0 = d0;
        v.v1 = v1; v.w1 = w1; v.l1 = l1; v.a1 = a1; v.d1 = d1;
        v.r0 = r0; v.r1 = r1; v.cs = cs; v.addr = ad; v.wd = wd;
        v.rv1 = rv1; v.err0 = er0; v.torn = tn;
        return v;
    endfunction

    vec_t tbl [40];

    initial begin
        // reset, concurrent writes
        tbl[0]  = mk(1,0, 0,0,0,0,0,          0,0,0,0,0,          0,0,0,0,0,          0,0,0);
        tbl[1]  = mk(0,0, 1,1,0,0,16'h0140,   1,1,0,2,16'h0100,   1,0,0,0,0,          0,0,0);
        tbl[2]  = mk(0,0, 1,1,0,0,16'h0140,   1,1,0,2,16'h0100,   0,1,1,0,16'h0140,   0,0,0);
        // req0 alone so req1 wins the following tie
        tbl[3]  = mk(0,0, 1,1,0,1,16'h2222,   0,0,0,0,0,          1,0,1,2,16'h0100,   0,0,0);
        // locked pair from req1 while req0 stays valid
        tbl[4]  = mk(0,0, 1,1,0,1,16'h2222,   1,1,1,4,16'h1111,   0,1,1,1,16'h2222,   0,0,0);
        tbl[5]  = mk(0,0, 1,1,0,1,16'h2222,   1,1,0,5,16'h3333,   0,1,1,4,16'h1111,   0,0,0);
        tbl[6]  = mk(0,0, 1,1,0,1,16'h2222,   0,0,0,0,0,          1,0,1,5,16'h3333,   0,0,0);
        tbl[7]  = mk(0,0, 0,0,0,0,0,          0,0,0,0,0,          0,0,1,1,16'h2222,   0,0,0);
        // MAX_LOCK: req0 locks 6 beats, req1 waiting
        tbl[8]  = mk(0,0, 1,1,1,0,16'h0010,   0,0,0,0,0,          1,0,0,0,0,          0,0,0);
        tbl[9]  = mk(0,0, 1,1,1,1,16'h0011,   1,1,0,3,16'h0AAA,   1,0,1,0,16'h0010,   0,0,0);
        tbl[10] = mk(0,0, 1,1,1,2,16'h0012,   1,1,0,3,16'h0AAA,   1,0,1,1,16'h0011,   0,0,0);
        tbl[11] = mk(0,0, 1,1,1,3,16'h0013,   1,1,0,3,16'h0AAA,   1,0,1,2,16'h0012,   0,0,0);
        tbl[12] = mk(0,0, 1,1,1,4,16'h0014,   1,1,0,3,16'h0AAA,   0,1,1,3,16'h0013,   0,0,0);
        tbl[13] = mk(0,0, 1,1,1,4,16'h0014,   0,0,0,0,0,          1,0,1,3,16'h0AAA,   0,0,0);
        tbl[14] = mk(0,0, 1,1,0,5,16'h0015,   0,0,0,0,0,          1,0,1,4,16'h0014,   0,0,0);
        tbl[15] = mk(0,0, 0,0,0,0,0,          0,0,0,0,0,          0,0,1,5,16'h0015,   0,0,0);
        // timeout: burst opened then owner silent for 8 cycles
        tbl[16] = mk(0,0, 1,1,1,6,16'h0016,   0,0,0,0,0,          1,0,0,0,0,          0,0,0);
        tbl[17] = mk(0,0, 0,0,0,0,0,          1,1,0,7,16'h0777,   0,0,1,6,16'h0016,   0,0,0);
        for (int i = 18; i <= 24; i++)
            tbl[i] = mk(0,0, 0,0,0,0,0,       1,1,0,7,16'h0777,   0,0,0,0,0,          0,0,0);
        tbl[25] = mk(0,0, 0,0,0,0,0,          1,1,0,7,16'h0777,   0,1,0,0,0,          0,0,0);
        tbl[26] = mk(0,0, 0,0,0,0,0,          0,0,0,0,0,          0,0,1,7,16'h0777,   0,0,0);
        // read from addr 9, then write to out-of-range addr 12
        tbl[27] = mk(0,0, 0,0,0,0,0,          1,0,0,9,16'hBEEF,   0,1,0,0,0,          0,0,0);
        tbl[28] = mk(0,0, 0,0,0,0,0,          0,0,0,0,0,          0,0,1,9,0,          0,0,0);
        tbl[29] = mk(0,0, 1,1,0,12,16'hFFFF,  0,0,0,0,0,          1,0,0,0,0,          1,0,0);
        tbl[30] = mk(0,0, 0,0,0,0,0,          0,0,0,0,0,          0,0,0,0,0,          0,1,0);
        tbl[31] = mk(0,0, 0,0,0,0,0,          0,0,0,0,0,          0,0,0,0,0,          0,0,0);
        // frame_end between beats, then on the final beat
        tbl[32] = mk(0,0, 1,1,1,0,16'h0100,   0,0,0,0,0,          1,0,0,0,0,          0,0,0);
        tbl[33] = mk(0,1, 0,0,0,0,0,          0,0,0,0,0,          0,0,1,0,16'h0100,   0,0,0);
        tbl[34] = mk(0,0, 1,1,0,1,16'h0101,   0,0,0,0,0,          1,0,0,0,0,          0,0,1);
        tbl[35] = mk(0,0, 0,0,0,0,0,          0,0,0,0,0,          0,0,1,1,16'h0101,   0,0,0);
        tbl[36] = mk(0,0, 1,1,1,2,16'h0102,   0,0,0,0,0,          1,0,0,0,0,          0,0,0);
        tbl[37] = mk(0,1, 1,1,0,3,16'h0103,   0,0,0,0,0,          1,0,1,2,16'h0102,   0,0,0);
        tbl[38] = mk(0,0, 0,0,0,0,0,          0,0,0,0,0,          0,0,1,3,16'h0103,   0,0,0);
        tbl[39] = mk(0,0, 0,0,0,0,0,          0,0,0,0,0,          0,0,0,0,0,          0,0,0);

        rst = 1; frame_end = 0; gfx_rdata = 16'h0002;
        req0_valid = 0; req0_write = 0; req0_lock = 0; req0_addr = 0; req0_wdata = 0;
        req1_valid = 0; req1_write = 0; req1_lock = 0; req1_addr = 0; req1_wdata = 0;
        model_step();
        @(posedge clk); @(posedge clk); #1;

        for (int i = 0; i < 40; i++) begin
            string tag;
            tag = $sformatf("row%0d", i);
            rst = tbl[i].rst; frame_end = tbl[i].fe; gfx_rdata = 16'h0002;
            req0_valid = tbl[i].v0; req0_write = tbl[i].w0; req0_lock = tbl[i].l0;
            req0_addr = tbl[i].a0; req0_wdata = tbl[i].d0;
            req1_valid = tbl[i].v1; req1_write = tbl[i].w1; req1_lock = tbl[i].l1;
            req1_addr = tbl[i].a1; req1_wdata = tbl[i].d1;
            #4;
            chk({tag, " tbl ready0"}, 16'(req0_ready), 16'(tbl[i].r0));
            chk({tag, " tbl ready1"}, 16'(req1_ready), 16'(tbl[i].r1));
            chk({tag, " tbl cs"},     16'(gfx_chipselect), 16'(tbl[i].cs));
            chk({tag, " tbl addr"},   16'(gfx_addr), 16'(tbl[i].addr));
            chk({tag, " tbl wdata"},  gfx_wdata, tbl[i].wd);
            chk({tag, " tbl rvalid1"},16'(req1_rvalid), 16'(tbl[i].rv1));
            chk({tag, " tbl err0"},   16'(req0_err), 16'(tbl[i].err0));
            chk({tag, " tbl torn"},   16'(torn), 16'(tbl[i].torn));
            model_compare(tag);
            model_step();
            @(posedge clk); #1;
        end

        for (int c = 0; c < 3000; c++) begin
            rst        = ($urandom_range(0, 199) == 0);
            frame_end  = ($urandom_range(0, 7) == 0);
            gfx_rdata  = 16'($urandom);
            req0_valid = ($urandom_range(0, 3) != 0);
            req0_write = 1'($urandom);
            req0_lock  = 1'($urandom);
            req0_addr  = 4'($urandom_range(0, 15));
            req0_wdata = 16'($urandom);
            req1_valid = ($urandom_range(0, 2) != 0);
            req1_write = 1'($urandom);
            req1_lock  = 1'($urandom);
            req1_addr  = 4'($urandom_range(0, 15));
            req1_wdata = 16'($urandom);
            #4;
            model_compare($sformatf("rnd%0d", c));
            model_step();
            @(posedge clk); #1;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
